// File: rtl/vga_timing_pkg.sv
// Shared VGA raster defaults, derived window origins and RGB565 colour constants.
// Counter width covers every default total (800, 525) with headroom.
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int PIX_W = 16;

  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 40;
  localparam int DEF_H_LEFT  = 8;
  localparam int DEF_H_VALID = 640;
  localparam int DEF_H_RIGHT = 8;
  localparam int DEF_H_FRONT = 8;
  localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_LEFT
                             + DEF_H_VALID + DEF_H_RIGHT + DEF_H_FRONT;

  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 25;
  localparam int DEF_V_TOP    = 8;
  localparam int DEF_V_VALID  = 480;
  localparam int DEF_V_BOTTOM = 8;
  localparam int DEF_V_FRONT  = 2;
  localparam int DEF_V_TOTAL  = DEF_V_SYNC + DEF_V_BACK + DEF_V_TOP
                              + DEF_V_VALID + DEF_V_BOTTOM + DEF_V_FRONT;

  // First active column / row, measured from the start of the sync pulse.
  localparam int DEF_HA = DEF_H_SYNC + DEF_H_BACK + DEF_H_LEFT;
  localparam int DEF_VA = DEF_V_SYNC + DEF_V_BACK + DEF_V_TOP;

  localparam logic [CNT_W-1:0] COORD_NONE = '1;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic rgb_valid;
    logic pix_req;
    logic frame_end;
  } vga_timing_t;

  function automatic logic [PIX_W-1:0] rgb565(input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
    return {r[7:3], g[7:2], b[7:3]};
  endfunction

  localparam logic [PIX_W-1:0] BLACK  = rgb565(8'd0,   8'd0,   8'd0);
  localparam logic [PIX_W-1:0] WHITE  = rgb565(8'd255, 8'd255, 8'd255);
  localparam logic [PIX_W-1:0] GOLDEN = rgb565(8'd255, 8'd215, 8'd0);

endpackage

// File: rtl/vga_sync_counter.sv
// One raster axis: wrapping counter plus raw sync and active-window decodes.
// sync is the in-pulse flag; polarity is applied by the caller.
module vga_sync_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = DEF_H_TOTAL,
  parameter int SYNC  = DEF_H_SYNC,
  parameter int START = DEF_HA,
  parameter int LEN   = DEF_H_VALID
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync,
  output logic             active
);

  localparam logic [CNT_W-1:0] LAST   = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_E = CNT_W'(SYNC);
  localparam logic [CNT_W-1:0] ACT_LO = CNT_W'(START);
  localparam logic [CNT_W-1:0] ACT_HI = CNT_W'(START + LEN);

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (wrap) count <= '0;
    else if (en)   count <= count + CNT_W'(1);
  end

  // Decodes are pure functions of the registered count, so they only move on clock edges.
  always_comb begin
    wrap   = en && (count == LAST);
    sync   = (count < SYNC_E);
    active = (count >= ACT_LO) && (count < ACT_HI);
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: H/V counters, sync outputs, one-cycle-early pixel
// coordinate request and gating of the returned pixel data onto rgb.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   H_LEFT   = DEF_H_LEFT,
  parameter int   H_VALID  = DEF_H_VALID,
  parameter int   H_RIGHT  = DEF_H_RIGHT,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_TOTAL  = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter int   V_TOP    = DEF_V_TOP,
  parameter int   V_VALID  = DEF_V_VALID,
  parameter int   V_BOTTOM = DEF_V_BOTTOM,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_TOTAL  = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_data,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             pix_req,
  output logic             hsync,
  output logic             vsync,
  output logic             rgb_valid,
  output logic [PIX_W-1:0] rgb,
  output logic             frame_end
);

  localparam int HA = H_SYNC + H_BACK + H_LEFT;
  localparam int VA = V_SYNC + V_BACK + V_TOP;

  // Request window is the active window shifted one clock earlier, clipped at the
  // line end so no request straddles into the next line.
  localparam logic [CNT_W-1:0] REQ_LO = CNT_W'(HA - 1);
  localparam logic [CNT_W-1:0] REQ_HI = CNT_W'(HA + H_VALID - 1);
  localparam logic [CNT_W-1:0] ROW_LO = CNT_W'(VA);

  logic [CNT_W-1:0] cnt_h, cnt_v;
  logic             h_wrap, v_wrap;
  logic             h_sync, v_sync;
  logic             h_act, v_act;
  logic             h_req;
  vga_timing_t      tim;

  vga_sync_counter #(
    .TOTAL (H_TOTAL),
    .SYNC  (H_SYNC),
    .START (HA),
    .LEN   (H_VALID)
  ) u_h (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .en      (1'b1),
    .count   (cnt_h),
    .wrap    (h_wrap),
    .sync    (h_sync),
    .active  (h_act)
  );

  vga_sync_counter #(
    .TOTAL (V_TOTAL),
    .SYNC  (V_SYNC),
    .START (VA),
    .LEN   (V_VALID)
  ) u_v (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .en      (h_wrap),
    .count   (cnt_v),
    .wrap    (v_wrap),
    .sync    (v_sync),
    .active  (v_act)
  );

  always_comb begin
    h_req         = (cnt_h >= REQ_LO) && (cnt_h < REQ_HI);
    tim           = '0;
    tim.hsync     = h_sync ? HS_POL : ~HS_POL;
    tim.vsync     = v_sync ? VS_POL : ~VS_POL;
    tim.rgb_valid = h_act && v_act;
    tim.pix_req   = h_req && v_act;
    tim.frame_end = v_wrap;
  end

  always_comb begin
    hsync     = tim.hsync;
    vsync     = tim.vsync;
    rgb_valid = tim.rgb_valid;
    pix_req   = tim.pix_req;
    frame_end = tim.frame_end;
    pix_x     = tim.pix_req ? (cnt_h - REQ_LO) : COORD_NONE;
    pix_y     = tim.pix_req ? (cnt_v - ROW_LO) : COORD_NONE;
    rgb       = tim.rgb_valid ? pix_data : BLACK;
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench: default 640x480 timing, a short-line/full-height instance and a
// tiny inverted-polarity instance, each fed by a registered coordinate echo.
module tb_vga_timing_ctrl;

  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int n_chk  = 0;
  int n_fail = 0;

  // default instance
  logic        rst_n = 1'b1;
  logic [15:0] pix_data;
  logic [9:0]  pix_x, pix_y;
  logic        pix_req, hsync, vsync, rgb_valid, frame_end;
  logic [15:0] rgb;
  // short lines (20 clks), default vertical
  logic        rst_t_n = 1'b1;
  logic [15:0] pix_data_t;
  logic [9:0]  pix_x_t, pix_y_t;
  logic        pix_req_t, hsync_t, vsync_t, rgb_valid_t, frame_end_t;
  logic [15:0] rgb_t;
  // 20x10 frame, active-low syncs
  logic        rst_s_n = 1'b1;
  logic [15:0] pix_data_s;
  logic [9:0]  pix_x_s, pix_y_s;
  logic        pix_req_s, hsync_s, vsync_s, rgb_valid_s, frame_end_s;
  logic [15:0] rgb_s;

  vga_timing_ctrl dut (
    .vga_clk(vga_clk), .rst_n(rst_n), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_req(pix_req), .hsync(hsync), .vsync(vsync), .rgb_valid(rgb_valid), .rgb(rgb),
    .frame_end(frame_end)
  );

  vga_timing_ctrl #(
    .H_SYNC(2), .H_BACK(2), .H_LEFT(1), .H_VALID(10), .H_RIGHT(2), .H_FRONT(3), .H_TOTAL(20)
  ) dut_t (
    .vga_clk(vga_clk), .rst_n(rst_t_n), .pix_data(pix_data_t), .pix_x(pix_x_t), .pix_y(pix_y_t),
    .pix_req(pix_req_t), .hsync(hsync_t), .vsync(vsync_t), .rgb_valid(rgb_valid_t), .rgb(rgb_t),
    .frame_end(frame_end_t)
  );

  vga_timing_ctrl #(
    .H_SYNC(2), .H_BACK(2), .H_LEFT(1), .H_VALID(10), .H_RIGHT(2), .H_FRONT(3), .H_TOTAL(20),
    .V_SYNC(1), .V_BACK(1), .V_TOP(1), .V_VALID(4), .V_BOTTOM(1), .V_FRONT(2), .V_TOTAL(10),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_s (
    .vga_clk(vga_clk), .rst_n(rst_s_n), .pix_data(pix_data_s), .pix_x(pix_x_s), .pix_y(pix_y_s),
    .pix_req(pix_req_s), .hsync(hsync_s), .vsync(vsync_s), .rgb_valid(rgb_valid_s), .rgb(rgb_s),
    .frame_end(frame_end_s)
  );

  // Pixel generator stand-in: registered echo of the requested coordinate.
  always @(posedge vga_clk) begin
    pix_data   <= {pix_x[5:0],   pix_y};
    pix_data_t <= {pix_x_t[5:0], pix_y_t};
    pix_data_s <= {pix_x_s[5:0], pix_y_s};
  end

  task automatic do_reset();
    @(negedge vga_clk);
    rst_n = 1'b0; rst_t_n = 1'b0; rst_s_n = 1'b0;
    repeat (2) @(negedge vga_clk);
    rst_n = 1'b1; rst_t_n = 1'b1; rst_s_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [40:0] obs, exp_v;
    @(negedge vga_clk);
    rst_n = 1'b0; rst_t_n = 1'b0; rst_s_n = 1'b0;
    @(negedge vga_clk);
    exp_v = {5'b11000, 10'h3FF, 10'h3FF, 16'h0000};
    obs   = {hsync, vsync, pix_req, rgb_valid, frame_end, pix_x, pix_y, rgb};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_default: got %h want %h", obs, exp_v); end
    exp_v = {5'b00000, 10'h3FF, 10'h3FF, 16'h0000};
    obs   = {hsync_s, vsync_s, pix_req_s, rgb_valid_s, frame_end_s, pix_x_s, pix_y_s, rgb_s};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL reset_lowpol: got %h want %h", obs, exp_v); end
    rst_n = 1'b1; rst_t_n = 1'b1; rst_s_n = 1'b1;
  endtask

  task automatic test_line();
    int hs0 = 0, hs1 = 0, first_low = -1, rise = -1, vs_low = 0, act = 0;
    do_reset();
    for (int i = 0; i < 1600; i++) begin
      if (hsync === 1'b1) begin if (i < 800) hs0++; else hs1++; end
      if (hsync !== 1'b1 && first_low < 0) first_low = i;
      if (hsync === 1'b1 && first_low >= 0 && rise < 0) rise = i;
      if (vsync !== 1'b1) vs_low++;
      if (pix_req !== 1'b0 || rgb_valid !== 1'b0 || rgb !== 16'h0 || pix_x !== 10'h3FF) act++;
      @(negedge vga_clk);
    end
    n_chk++; if (hs0 !== 96) begin n_fail++; $display("FAIL hsync_width_l0: got %0d want 96", hs0); end
    n_chk++; if (hs1 !== 96) begin n_fail++; $display("FAIL hsync_width_l1: got %0d want 96", hs1); end
    n_chk++; if (first_low !== 96) begin n_fail++; $display("FAIL hsync_fall: got %0d want 96", first_low); end
    n_chk++; if (rise !== 800) begin n_fail++; $display("FAIL line_period: got %0d want 800", rise); end
    n_chk++; if (vs_low !== 0) begin n_fail++; $display("FAIL vsync_lines01: got %0d low clks want 0", vs_low); end
    n_chk++; if (act !== 0) begin n_fail++; $display("FAIL blank_lines: got %0d active clks want 0", act); end
    n_chk++; if (vsync !== 1'b0) begin n_fail++; $display("FAIL vsync_line2: got %b want 0", vsync); end
  endtask

  task automatic test_frame();
    int fe = 0, fe1 = -1, fe2 = -1, vs_hi = 0, vs_fall = -1;
    int rq = 0, rq_lines = 0, first_rq = -1, last_rq = -1, stray = 0;
    logic [19:0] first_xy = '0, last_xy = '0;
    do_reset();
    for (int i = 0; i <= 21000; i++) begin
      if (frame_end_t === 1'b1) begin
        fe++;
        if (fe == 1) fe1 = i; else if (fe == 2) fe2 = i;
      end
      if (i < 10500 && vsync_t === 1'b1) vs_hi++;
      if (vsync_t !== 1'b1 && vs_fall < 0) vs_fall = i;
      if (i < 10500 && pix_req_t === 1'b1) begin
        rq++;
        if (first_rq < 0) begin first_rq = i; first_xy = {pix_x_t, pix_y_t}; end
        last_rq = i; last_xy = {pix_x_t, pix_y_t};
        if (i % 20 == 4) rq_lines++;
      end
      if (pix_req_t !== 1'b1 && {pix_x_t, pix_y_t} !== 20'hFFFFF) stray++;
      @(negedge vga_clk);
    end
    n_chk++; if (fe !== 2) begin n_fail++; $display("FAIL frame_end_count: got %0d want 2", fe); end
    n_chk++; if (fe1 !== 10499) begin n_fail++; $display("FAIL frame_end_first: got %0d want 10499", fe1); end
    n_chk++; if (fe2 !== 20999) begin n_fail++; $display("FAIL frame_period: got %0d want 20999", fe2); end
    n_chk++; if (vs_hi !== 40) begin n_fail++; $display("FAIL vsync_width: got %0d want 40", vs_hi); end
    n_chk++; if (vs_fall !== 40) begin n_fail++; $display("FAIL vsync_fall: got %0d want 40", vs_fall); end
    n_chk++; if (rq !== 4800) begin n_fail++; $display("FAIL req_total: got %0d want 4800", rq); end
    n_chk++; if (rq_lines !== 480) begin n_fail++; $display("FAIL req_lines: got %0d want 480", rq_lines); end
    n_chk++; if (first_rq !== 704) begin n_fail++; $display("FAIL req_first_pos: got %0d want 704", first_rq); end
    n_chk++; if (first_xy !== 20'h0) begin n_fail++; $display("FAIL req_first_xy: got %h want 00000", first_xy); end
    n_chk++; if (last_rq !== 10293) begin n_fail++; $display("FAIL req_last_pos: got %0d want 10293", last_rq); end
    n_chk++;
    if (last_xy !== {10'd9, 10'd479}) begin n_fail++; $display("FAIL req_last_xy: got %h want %h", last_xy, {10'd9, 10'd479}); end
    n_chk++; if (stray !== 0) begin n_fail++; $display("FAIL coord_outside: got %0d want 0", stray); end
  endtask

  task automatic test_latency();
    int bad = 0, bad_at = -1, h, row;
    int reqc[2] = '{0, 0};
    logic [15:0] exp_rgb, bad_got = '0, bad_exp = '0;
    do_reset();
    repeat (35 * 800) @(negedge vga_clk);
    for (int i = 0; i < 1600; i++) begin
      h = i % 800;
      row = i / 800;
      exp_rgb = (h >= 144 && h < 784) ? {6'(h - 144), 10'(row)} : 16'h0000;
      if (rgb !== exp_rgb) begin
        if (bad == 0) begin bad_at = i; bad_got = rgb; bad_exp = exp_rgb; end
        bad++;
      end
      if (pix_req === 1'b1) reqc[row]++;
      if (row == 0 && h == 142) begin
        n_chk++; if (pix_req !== 1'b0) begin n_fail++; $display("FAIL req_early: got %b want 0", pix_req); end
      end
      if (row == 0 && h == 143) begin
        n_chk++;
        if ({pix_req, pix_x, pix_y} !== 21'h100000) begin
          n_fail++; $display("FAIL req_first: got %b/%0d/%0d want 1/0/0", pix_req, pix_x, pix_y);
        end
      end
      if (row == 1 && h == 782) begin
        n_chk++;
        if ({pix_req, pix_x, pix_y} !== {1'b1, 10'd639, 10'd1}) begin
          n_fail++; $display("FAIL req_last_col: got %b/%0d/%0d want 1/639/1", pix_req, pix_x, pix_y);
        end
      end
      if (row == 0 && h == 783) begin
        n_chk++;
        if ({pix_req, pix_x} !== {1'b0, 10'h3FF}) begin
          n_fail++; $display("FAIL req_line_end: got %b/%h want 0/3ff", pix_req, pix_x);
        end
      end
      if (row == 0 && (h == 143 || h == 144 || h == 783 || h == 784)) begin
        n_chk++;
        if (rgb_valid !== (h == 144 || h == 783)) begin
          n_fail++; $display("FAIL rgb_valid_edge_%0d: got %b want %b", h, rgb_valid, (h == 144 || h == 783));
        end
      end
      @(negedge vga_clk);
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL rgb_echo: %0d bad, first at %0d got %h want %h", bad, bad_at, bad_got, bad_exp);
    end
    n_chk++; if (reqc[0] !== 640) begin n_fail++; $display("FAIL req_count_r0: got %0d want 640", reqc[0]); end
    n_chk++; if (reqc[1] !== 640) begin n_fail++; $display("FAIL req_count_r1: got %0d want 640", reqc[1]); end
  endtask

  // Continues from test_latency: the raster now sits at column 0 of line 37 (row 2).
  task automatic test_reset_mid();
    logic [40:0] obs, exp_v;
    int first_low = -1;
    repeat (400) @(negedge vga_clk);
    n_chk++;
    if ({rgb_valid, rgb, pix_x, pix_y} !== {1'b1, 16'h0002, 10'd257, 10'd2}) begin
      n_fail++; $display("FAIL mid_line_state: got %b/%h/%0d/%0d want 1/0002/257/2", rgb_valid, rgb, pix_x, pix_y);
    end
    rst_n = 1'b0;
    #1;
    exp_v = {5'b11000, 10'h3FF, 10'h3FF, 16'h0000};
    obs   = {hsync, vsync, pix_req, rgb_valid, frame_end, pix_x, pix_y, rgb};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_reset_async: got %h want %h", obs, exp_v); end
    repeat (2) @(negedge vga_clk);
    rst_n = 1'b1;
    obs = {hsync, vsync, pix_req, rgb_valid, frame_end, pix_x, pix_y, rgb};
    n_chk++;
    if (obs !== exp_v) begin n_fail++; $display("FAIL mid_reset_release: got %h want %h", obs, exp_v); end
    for (int i = 0; i < 100; i++) begin
      if (hsync !== 1'b1 && first_low < 0) first_low = i;
      @(negedge vga_clk);
    end
    n_chk++; if (first_low !== 96) begin n_fail++; $display("FAIL mid_restart_h0: got %0d want 96", first_low); end
  endtask

  task automatic test_small();
    int h, v, bad = 0, rq = 0;
    logic rq_e, rv_e;
    logic [40:0] obs, exp_v;
    do_reset();
    for (int i = 0; i <= 200; i++) begin
      h = i % 20;
      v = (i / 20) % 10;
      rq_e = (h >= 4 && h < 14) && (v >= 3 && v < 7);
      rv_e = (h >= 5 && h < 15) && (v >= 3 && v < 7);
      exp_v = {(h >= 2), (v >= 1), rq_e, rv_e, (h == 19 && v == 9),
               rq_e ? 10'(h - 4) : 10'h3FF, rq_e ? 10'(v - 3) : 10'h3FF,
               rv_e ? {6'(h - 5), 10'(v - 3)} : 16'h0000};
      obs = {hsync_s, vsync_s, pix_req_s, rgb_valid_s, frame_end_s, pix_x_s, pix_y_s, rgb_s};
      if (pix_req_s === 1'b1 && i < 200) rq++;
      n_chk++;
      if (obs !== exp_v) begin
        n_fail++; bad++;
        $display("FAIL small_decode h=%0d v=%0d: got %h want %h", h, v, obs, exp_v);
      end
      @(negedge vga_clk);
    end
    n_chk++; if (rq !== 40) begin n_fail++; $display("FAIL small_req_total: got %0d want 40", rq); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_latency();
    test_reset_mid();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
